instr_sequencer: RTL and testbench

INSTR_SEQUENCER -- requirements
Module: instr_sequencer

---
 rtl/instr_sequencer_pkg.sv | 31 +++
 rtl/instr_sequencer_prog_mem.sv | 33 +++
 rtl/instr_sequencer.sv | 145 ++++++++++++++
 tb/tb_instr_sequencer.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/instr_sequencer_pkg.sv
// ============================================================================
// instr_sequencer_pkg : shared types and constants for the instruction sequencer
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

package instr_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } seq_state_t;

    // Idle presentation: opcode 0111 is the core's NOP, which writes no register
    localparam logic [7:0] NOP_HI = 8'h70;
    localparam logic [7:0] NOP_LO = 8'h00;

    localparam logic [3:0] OP_ADD = 4'h0;
    localparam logic [3:0] OP_SUB = 4'h1;
    localparam logic [3:0] OP_AND = 4'h2;
    localparam logic [3:0] OP_OR  = 4'h3;
    localparam logic [3:0] OP_XOR = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_MOV = 4'h6;
    localparam logic [3:0] OP_NOP = 4'h7;

endpackage

`default_nettype wire

// File: rtl/instr_sequencer_prog_mem.sv
// ============================================================================
// instr_sequencer_prog_mem : DEPTH x 16 program store, sync write, async read
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_sequencer_prog_mem
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [15:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [15:0]       rdata
);

    logic [15:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

`default_nettype wire

// File: rtl/instr_sequencer.sv
// ============================================================================
// instr_sequencer : byte-loaded program store replayed word-per-cycle to a core
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_valid,
    input  logic [7:0]        load_byte,
    output logic              load_ready,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    output logic [7:0]        inst_hi,
    output logic [7:0]        inst_lo,
    output logic              inst_valid,
    output logic [ADDR_W-1:0] pc,
    output logic              busy,
    output logic              done
);

    localparam logic [ADDR_W:0] C_DEPTH = (ADDR_W+1)'(DEPTH);

    seq_state_t        state_q, state_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic [7:0]        hi_byte_q, hi_byte_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [7:0]        inst_hi_q, inst_hi_d;
    logic [7:0]        inst_lo_q, inst_lo_d;
    logic              inst_valid_q, inst_valid_d;
    logic              done_q, done_d;

    logic              accept;
    logic              last_word;
    logic              mem_we;
    logic [ADDR_W-1:0] rd_addr;
    logic [15:0]       rd_data;

    assign load_ready = (state_q != ST_RUN) && (count_q < C_DEPTH);
    assign accept     = load_valid && load_ready;
    assign last_word  = ({1'b0, pc_q} == (count_q - (ADDR_W+1)'(1)));
    // Outside RUN the only word ever fetched is word 0 (the start case)
    assign rd_addr    = (state_q == ST_RUN) ? (pc_q + ADDR_W'(1)) : '0;

    instr_sequencer_prog_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (count_q[ADDR_W-1:0]),
        .wdata ({hi_byte_q, load_byte}),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        hi_byte_d    = hi_byte_q;
        pc_d         = pc_q;
        inst_hi_d    = NOP_HI;
        inst_lo_d    = NOP_LO;
        inst_valid_d = 1'b0;
        done_d       = 1'b0;
        mem_we       = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (last_word) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end else begin
                    pc_d         = pc_q + ADDR_W'(1);
                    inst_hi_d    = rd_data[15:8];
                    inst_lo_d    = rd_data[7:0];
                    inst_valid_d = 1'b1;
                end
            end
            default: begin
                // IDLE, LOAD and DONE share load / start / clear handling
                if (clear) begin
                    count_d = '0;
                    state_d = ST_IDLE;
                end else if (accept) begin
                    if (state_q == ST_LOAD) begin
                        mem_we  = 1'b1;
                        count_d = count_q + (ADDR_W+1)'(1);
                        state_d = ST_IDLE;
                    end else begin
                        hi_byte_d = load_byte;
                        state_d   = ST_LOAD;
                    end
                end else if (start && (state_q != ST_LOAD) && (count_q != '0)) begin
                    state_d      = ST_RUN;
                    pc_d         = '0;
                    inst_hi_d    = rd_data[15:8];
                    inst_lo_d    = rd_data[7:0];
                    inst_valid_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            hi_byte_q    <= '0;
            pc_q         <= '0;
            inst_hi_q    <= NOP_HI;
            inst_lo_q    <= NOP_LO;
            inst_valid_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            hi_byte_q    <= hi_byte_d;
            pc_q         <= pc_d;
            inst_hi_q    <= inst_hi_d;
            inst_lo_q    <= inst_lo_d;
            inst_valid_q <= inst_valid_d;
            done_q       <= done_d;
        end
    end

    assign inst_hi    = inst_hi_q;
    assign inst_lo    = inst_lo_q;
    assign inst_valid = inst_valid_q;
    assign pc         = pc_q;
    assign busy       = (state_q == ST_RUN);
    assign done       = done_q;

endmodule

`default_nettype wire

// File: tb/tb_instr_sequencer.sv
// ============================================================================
// tb_instr_sequencer : directed + random stimulus against a program-level model
// Rev 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_sequencer;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              load_valid;
    logic [7:0]        load_byte;
    logic              load_ready;
    logic              start;
    logic              stop;
    logic              clear;
    logic [7:0]        inst_hi;
    logic [7:0]        inst_lo;
    logic              inst_valid;
    logic [ADDR_W-1:0] pc;
    logic              busy;
    logic              done;

    instr_sequencer #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_byte  (load_byte),
        .load_ready (load_ready),
        .start      (start),
        .stop       (stop),
        .clear      (clear),
        .inst_hi    (inst_hi),
        .inst_lo    (inst_lo),
        .inst_valid (inst_valid),
        .pc         (pc),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Program-level model: stored words, pending high byte, replay cursor
    logic [15:0] m_prog [DEPTH];
    int          m_cnt;
    bit          m_half;
    logic [7:0]  m_hi;
    bit          m_run;
    int          m_idx;
    int          m_pc;
    bit          m_done;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outs();
        logic [15:0] w;
        w = m_run ? m_prog[m_idx] : 16'h7000;
        chk("inst_valid", 32'(inst_valid), 32'(m_run));
        chk("inst_hi", 32'(inst_hi), 32'(w[15:8]));
        chk("inst_lo", 32'(inst_lo), 32'(w[7:0]));
        chk("pc", 32'(pc), 32'(m_pc));
        chk("busy", 32'(busy), 32'(m_run));
        chk("done", 32'(done), 32'(m_done));
        chk("count", 32'(dut.count_q), 32'(m_cnt));
    endtask

    task automatic tick(input bit lv, input logic [7:0] lb, input bit st, input bit sp, input bit cl);
        bit ready_exp;
        load_valid = lv;
        load_byte  = lb;
        start      = st;
        stop       = sp;
        clear      = cl;
        #1;
        ready_exp = !m_run && (m_cnt < DEPTH);
        chk("load_ready", 32'(load_ready), 32'(ready_exp));
        m_done = 1'b0;
        if (m_run) begin
            if (sp) begin
                m_run = 1'b0;
            end else if (m_idx == m_cnt - 1) begin
                m_run  = 1'b0;
                m_done = 1'b1;
            end else begin
                m_idx++;
                m_pc = m_idx;
            end
        end else if (cl) begin
            m_cnt  = 0;
            m_half = 1'b0;
        end else if (lv && ready_exp) begin
            if (!m_half) begin
                m_hi   = lb;
                m_half = 1'b1;
            end else begin
                m_prog[m_cnt] = {m_hi, lb};
                m_cnt++;
                m_half = 1'b0;
            end
        end else if (st && !m_half && m_cnt > 0) begin
            m_run = 1'b1;
            m_idx = 0;
            m_pc  = 0;
        end
        @(posedge clk);
        #1;
        check_outs();
    endtask

    task automatic do_reset(input int cycles);
        rst_n      = 1'b0;
        load_valid = 1'b1;
        load_byte  = 8'hC3;
        start      = 1'b1;
        stop       = 1'b0;
        clear      = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            #1;
            m_cnt  = 0;
            m_half = 1'b0;
            m_run  = 1'b0;
            m_idx  = 0;
            m_pc   = 0;
            m_done = 1'b0;
            check_outs();
        end
        rst_n = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] prog_a [6];
        int guard;
        prog_a = '{8'h10, 8'h05, 8'hB3, 8'h12, 8'h20, 8'h03};

        m_cnt = 0; m_half = 0; m_hi = 0; m_run = 0; m_idx = 0; m_pc = 0; m_done = 0;
        do_reset(2);

        // Three-word program and its replay
        foreach (prog_a[i]) tick(1'b1, prog_a[i], 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("first_word_hi", 32'(inst_hi), 32'h10);
        chk("first_word_lo", 32'(inst_lo), 32'h05);
        idle(5);

        // Start with empty store, then start colliding with a byte, then start in LOAD
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 8'hA5, 1'b1, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        tick(1'b1, 8'h5A, 1'b0, 1'b0, 1'b0);

        // Half-loaded word discarded by clear
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        tick(1'b1, 8'h80, 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("word0_after_clear", 32'({inst_hi, inst_lo}), 32'h8012);
        idle(3);

        // Fill to capacity, then an extra byte
        tick(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 2 * DEPTH; i++) tick(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
        tick(1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
        chk("full_count", 32'(dut.count_q), 32'(DEPTH));

        // Stop mid-run (clear alongside is ignored), then a full re-run
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        guard = 0;
        while (m_pc != 5 && guard < 20) begin
            idle(1);
            guard++;
        end
        tick(1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
        idle(1);
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(DEPTH + 2);

        // Reset in the middle of a run
        tick(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        idle(3);
        do_reset(1);
        idle(1);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset(1);
            end else begin
                tick(($urandom_range(0, 2) != 0), 8'($urandom),
                     ($urandom_range(0, 5) == 0), ($urandom_range(0, 15) == 0),
                     ($urandom_range(0, 40) == 0));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
